// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM encoding and skid-buffer sizing.
package fetch_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, decode and control signals of the fetch sequencer; master is the sequencer side.
interface fetch_sequencer_if #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned MEM_LENGHT  = 32
);

    localparam int unsigned AW = $clog2(MEM_LENGHT);

    logic                   run;
    logic [AW-1:0]          rom_addr;
    logic [DATA_LENGTH-1:0] rom_data;
    logic [DATA_LENGTH-1:0] instr;
    logic [AW-1:0]          instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   redirect_valid;
    logic [AW-1:0]          redirect_pc;
    logic                   busy;

    modport master (
        input  run, rom_data, instr_ready, redirect_valid, redirect_pc,
        output rom_addr, instr, instr_pc, instr_valid, busy
    );

    modport slave (
        output run, rom_data, instr_ready, redirect_valid, redirect_pc,
        input  rom_addr, instr, instr_pc, instr_valid, busy
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry shift FIFO of {pc, instr}; entry 0 is always the head so outputs come straight from flops.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned AW          = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [AW-1:0]          push_pc,
    input  logic [DATA_LENGTH-1:0] push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic [AW-1:0]          head_pc,
    output logic [DATA_LENGTH-1:0] head_instr,
    output logic                   head_valid,
    output logic [CNT_W-1:0]       count
);

    logic [AW-1:0]          pc0_q, pc0_d, pc1_q, pc1_d;
    logic [DATA_LENGTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;

    always_comb begin
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        ins0_d  = ins0_q;
        ins1_d  = ins1_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) begin
                        pc0_d  = push_pc;
                        ins0_d = push_instr;
                    end else begin
                        pc1_d  = push_pc;
                        ins1_d = push_instr;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    pc0_d   = pc1_q;
                    ins0_d  = ins1_q;
                    count_d = count_q - CNT_W'(1);
                end
                2'b11: begin
                    // Simultaneous push/pop: the new entry lands behind whatever remains.
                    if (count_q == CNT_W'(1)) begin
                        pc0_d  = push_pc;
                        ins0_d = push_instr;
                    end else begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = push_pc;
                        ins1_d = push_instr;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc0_q   <= '0;
            pc1_q   <= '0;
            ins0_q  <= '0;
            ins1_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            ins0_q  <= ins0_d;
            ins1_q  <= ins1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == CNT_W'(SKID_DEPTH)));

    assign head_pc    = pc0_q;
    assign head_instr = ins0_q;
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, tracks the single in-flight ROM read and feeds decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned MEM_LENGHT  = 32,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    localparam int unsigned AW    = $clog2(MEM_LENGHT);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [AW-1:0]    inflight_pc_q, inflight_pc_d;
    logic             busy_q, busy_d;

    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             pop_c, redirect_c, issue_c;
    logic [SUM_W-1:0] occ_c;
    logic [AW-1:0]    pc_inc_c;

    // Occupancy after this edge's push/pop; crediting the pop keeps one fetch per cycle streaming.
    always_comb begin
        pop_c      = head_valid & bus.instr_ready;
        redirect_c = bus.redirect_valid && (state_q != S_BOOT);
        occ_c      = SUM_W'(count) + SUM_W'(inflight_q) - SUM_W'(pop_c);
        issue_c    = (state_q == S_RUN) && bus.run && !redirect_c &&
                     (occ_c < SUM_W'(SKID_DEPTH));
        pc_inc_c   = (pc_q == AW'(MEM_LENGHT - 1)) ? '0 : pc_q + AW'(1);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            S_BOOT:  if (bus.run)  state_d = S_RUN;
            S_RUN:   if (!bus.run) state_d = S_STOP;
            S_STOP:  if (bus.run)  state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (redirect_c) begin
            pc_d = bus.redirect_pc;
        end else if (issue_c) begin
            pc_d          = pc_inc_c;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
        busy_d = !redirect_c && ((occ_c != '0) || inflight_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= AW'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            busy_q        <= busy_d;
        end
    end

    // The ROM samples pc_q at the issue edge, so its data is ready to push the following cycle.
    fetch_skid_buf #(
        .DATA_LENGTH (DATA_LENGTH),
        .AW          (AW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_pc    (inflight_pc_q),
        .push_instr (bus.rom_data),
        .pop        (pop_c),
        .flush      (redirect_c),
        .head_pc    (bus.instr_pc),
        .head_instr (bus.instr),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle table, corner-case sequences and a random scoreboard run.
module tb_fetch_sequencer;

    localparam int unsigned DL = 32;
    localparam int unsigned ML = 32;
    localparam int unsigned AW = 5;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fetch_sequencer_if #(.DATA_LENGTH(DL), .MEM_LENGHT(ML)) bus ();

    fetch_sequencer #(.DATA_LENGTH(DL), .MEM_LENGHT(ML), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic rd,
                         input logic rv, input logic [AW-1:0] rp);
        rst                = r;
        bus.run            = ru;
        bus.instr_ready    = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic          rst, run, rdy, rv;
        logic [AW-1:0] rpc;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic          e_busy;
        logic [AW-1:0] e_addr;
        logic          chk_head;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ru, input logic rd, input logic rv,
                                input int rp, input logic ev, input int ep, input logic eb,
                                input int ea, input logic ch);
        vec_t v;
        v.rst = r; v.run = ru; v.rdy = rd; v.rv = rv; v.rpc = AW'(rp);
        v.e_valid = ev; v.e_pc = AW'(ep); v.e_busy = eb; v.e_addr = AW'(ea); v.chk_head = ch;
        return v;
    endfunction

    vec_t          tbl[$];
    bit            ok;
    int            n;
    int            delivered;
    bit            drained;
    logic [AW-1:0] last_pc;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] prev_pc;
    logic [AW-1:0] rp;
    logic          r, ru, rd, rv;
    bit            booted, prev_stall, prev_flush, prev_rst, hs, eff_rv;
    int            pops;

    initial begin
        // Row i: inputs held across one rising edge, outputs expected after that edge.
        tbl.push_back(mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0,  0, 1,  1, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  2, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  1, 1,  3, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  2, 1,  4, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2, 1, 4, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  3, 1,  5, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  4, 1,  6, 1));
        tbl.push_back(mk(0, 1, 1, 1, 20, 0,  0, 0, 20, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0,  0, 1, 21, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1, 20, 1, 22, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1, 21, 1, 23, 1));
        tbl.push_back(mk(0, 1, 1, 1, 30, 0,  0, 0, 30, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0,  0, 1, 31, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1, 30, 1,  0, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1, 31, 1,  1, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  2, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            tick();
            chk($sformatf("tbl%0d.valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.rom_addr", i), 32'(bus.rom_addr), 32'(tbl[i].e_addr));
            if (tbl[i].chk_head) begin
                chk($sformatf("tbl%0d.instr_pc", i), 32'(bus.instr_pc), 32'(tbl[i].e_pc));
                chk($sformatf("tbl%0d.instr", i), bus.instr,
                    tbl[i].rst ? 32'h0 : rom_word(tbl[i].e_pc));
            end
        end

        // Redirect with one entry buffered and a read in flight: the in-flight result is dropped.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0); repeat (3) tick();
        chk("A.fill_valid", 32'(bus.instr_valid), 32'd1);
        chk("A.fill_pc", 32'(bus.instr_pc), 32'd0);
        drive(0, 1, 0, 1, 5'd20); tick();
        chk("A.flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("A.flush_addr", 32'(bus.rom_addr), 32'd20);
        drive(0, 1, 1, 0, 0);
        wait_valid(8, ok, n);
        chk("A.wait", 32'(ok), 32'd1);
        chk("A.first_pc", 32'(bus.instr_pc), 32'd20);
        chk("A.first_instr", bus.instr, rom_word(5'd20));
        tick();
        chk("A.second_pc", 32'(bus.instr_pc), 32'd21);

        // Stop mid-stream: drain, then resume where the stream left off.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0);
        wait_valid(10, ok, n);
        chk("B.wait", 32'(ok), 32'd1);
        repeat (3) tick();
        drive(0, 0, 1, 0, 0);
        delivered = 0;
        drained   = 1'b0;
        last_pc   = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.instr_valid) begin
                delivered++;
                last_pc = bus.instr_pc;
            end
            tick();
            if (!bus.busy) begin
                drained = 1'b1;
                break;
            end
        end
        chk("B.drained", 32'(drained), 32'd1);
        chk("B.delivered_1to2", 32'(delivered >= 1 && delivered <= 2), 32'd1);
        chk("B.idle_valid", 32'(bus.instr_valid), 32'd0);
        drive(0, 1, 1, 0, 0);
        wait_valid(10, ok, n);
        chk("B.resume_wait", 32'(ok), 32'd1);
        chk("B.resume_pc", 32'(bus.instr_pc), 32'(AW'(last_pc + AW'(1))));

        // Reset with a full buffer, then restart from RESET_PC.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0); repeat (5) tick();
        chk("C.full_valid", 32'(bus.instr_valid), 32'd1);
        drive(1, 1, 0, 0, 0); tick();
        chk("C.rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("C.rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("C.rst_busy", 32'(bus.busy), 32'd0);
        chk("C.rst_pc", 32'(bus.instr_pc), 32'd0);
        drive(0, 1, 1, 0, 0);
        wait_valid(10, ok, n);
        chk("C.wait", 32'(ok), 32'd1);
        // One edge to leave boot, then two more until the first instruction is presented.
        chk("C.latency", 32'(n), 32'd3);
        chk("C.first_pc", 32'(bus.instr_pc), 32'd0);
        chk("C.first_instr", bus.instr, 32'hA000_0000);

        // Random traffic against an in-order delivery scoreboard.
        drive(1, 0, 0, 0, 0); tick();
        exp_pc     = '0;
        booted     = 1'b0;
        prev_stall = 1'b0;
        prev_flush = 1'b0;
        prev_rst   = 1'b1;
        prev_pc    = '0;
        pops       = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_rst) begin
                chk("R.rst_valid", 32'(bus.instr_valid), 32'd0);
                chk("R.rst_addr", 32'(bus.rom_addr), 32'd0);
            end
            if (prev_flush) chk("R.flush_valid", 32'(bus.instr_valid), 32'd0);
            if (prev_stall) begin
                chk("R.hold_valid", 32'(bus.instr_valid), 32'd1);
                chk("R.hold_pc", 32'(bus.instr_pc), 32'(prev_pc));
            end
            if (bus.instr_valid) begin
                chk("R.instr_data", bus.instr, rom_word(bus.instr_pc));
                chk("R.busy_with_valid", 32'(bus.busy), 32'd1);
            end
            r  = ($urandom_range(0, 199) == 0);
            ru = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 24) == 0);
            rp = AW'($urandom_range(0, ML - 1));
            drive(r, ru, rd, rv, rp);
            hs     = bus.instr_valid && rd && !r;
            eff_rv = rv && booted && !r;
            if (hs) begin
                chk("R.order_pc", 32'(bus.instr_pc), 32'(exp_pc));
                exp_pc = AW'((32'(exp_pc) + 32'd1) % ML);
                pops++;
            end
            if (r) begin
                exp_pc = '0;
                booted = 1'b0;
            end else begin
                if (eff_rv) exp_pc = rp;
                if (ru) booted = 1'b1;
            end
            prev_rst   = r;
            prev_flush = eff_rv;
            prev_stall = bus.instr_valid && !rd && !r && !eff_rv;
            prev_pc    = bus.instr_pc;
            tick();
        end
        chk("R.progress", 32'(pops > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
